// File: rtl/if_id_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The fetch stage is the master; the memory model or imem controller is the slave.
interface if_id_fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/if_id_fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register, load-use stall handling
// and a DRAIN state that parks a redirect until the outstanding fetch returns.
module if_id_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    PCWrite,
   input  logic                    IF_ID_Write,
   input  logic                    IF_Flush,
   input  logic                    PCSrc,
   input  logic [31:0]             Branch_target,
   if_id_fetch_stage_if.master     imem,
   output logic [31:0]             IF_ID_Instr,
   output logic [31:0]             IF_ID_PC4,
   output logic                    IF_ID_Valid,
   output logic [5:0]              IF_ID_Opcode,
   output logic [4:0]              IF_ID_RegisterRs,
   output logic [4:0]              IF_ID_RegisterRt,
   output logic [4:0]              IF_ID_RegisterRd,
   output logic                    fetch_stall,
   output logic [CNT_W-1:0]        fetch_stall_cnt
);

   typedef enum logic {FETCH, DRAIN} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      redirect_pc_d = redirect_pc_q;
      instr_d       = instr_q;
      pc4_d         = pc4_q;
      valid_d       = valid_q;
      cnt_d         = cnt_q;
      fetch_stall   = (state_q == DRAIN) || !imem.imem_ready;

      if (state_q == FETCH && imem.imem_ready) begin
         if (PCSrc) begin
            pc_d = Branch_target;
         end else if (PCWrite) begin
            pc_d = pc_plus4;
         end
         if (IF_Flush) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
         end else if (IF_ID_Write) begin
            instr_d = imem.imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
         end
      end else begin
         // No usable word this cycle: a requested load becomes a bubble instead.
         if (IF_Flush || IF_ID_Write) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
         end
         if (PCSrc) begin
            redirect_pc_d = Branch_target;
         end
         if (state_q == FETCH) begin
            if (PCSrc) begin
               state_d = DRAIN;
            end
         end else if (imem.imem_ready) begin
            pc_d    = PCSrc ? Branch_target : redirect_pc_q;
            state_d = FETCH;
         end
      end

      if (fetch_stall && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         redirect_pc_q <= RESET_PC;
         instr_q       <= 32'h0;
         pc4_q         <= 32'h0;
         valid_q       <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         redirect_pc_q <= redirect_pc_d;
         instr_q       <= instr_d;
         pc4_q         <= pc4_d;
         valid_q       <= valid_d;
         cnt_q         <= cnt_d;
      end
   end

   assign imem.imem_req    = !reset;
   assign imem.imem_addr   = pc_q;

   assign IF_ID_Instr      = instr_q;
   assign IF_ID_PC4        = pc4_q;
   assign IF_ID_Valid      = valid_q;
   assign IF_ID_Opcode     = instr_q[31:26];
   assign IF_ID_RegisterRs = instr_q[25:21];
   assign IF_ID_RegisterRt = instr_q[20:16];
   assign IF_ID_RegisterRd = instr_q[15:11];
   assign fetch_stall_cnt  = cnt_q;

endmodule
